// File: rtl/iob_bus_arbiter_2to1_pkg.sv
// Shared constants for the 2:1 IOb memory-port arbiter.
//   ST_*            : FSM state encodings (IDLE / read outstanding)
//   FIXED_PRIO_DEF  : default grant policy (0 round-robin, 1 data port wins ties)
//   *_W_DEF         : default bus and counter widths
package iob_bus_arbiter_2to1_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;

    localparam int FIXED_PRIO_DEF = 0;
    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-way grant logic with a remembered last winner.
//   clk_i/rst_i/cke_i : clock, sync active-high reset, clock enable
//   req_i[1:0]        : request vector (already masked by the caller's FSM)
//   upd_i             : the current grant was accepted; remember it
//   gnt_vld_o         : some port is granted this cycle
//   gnt_o             : index of the granted port
module iob_rr_arb2
    import iob_bus_arbiter_2to1_pkg::*;
#(
    parameter int FIXED_PRIO = FIXED_PRIO_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cke_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic       gnt_vld_o,
    output logic       gnt_o
);

    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt_vld_o = |req_i;
        case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            // Tie: fixed priority favours the data port, otherwise take
            // whichever port did not win last time.
            2'b11:   gnt_o = (FIXED_PRIO != 0) ? 1'b1 : ~last_gnt_q;
            default: gnt_o = 1'b0;
        endcase
        last_gnt_d = upd_i ? gnt_o : last_gnt_q;
    end

    // Starts at 1 so that the instruction port wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_q <= 1'b1;
        end else if (cke_i) begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/iob_bus_arbiter_2to1.sv
// Shares one IOb native memory port between the CPU instruction bus (s0)
// and data bus (s1). At most one read is outstanding; its response is
// steered back to the port that issued it. Accepted requests are counted
// per port.
//   clk_i, rst_i, cke_i    : clock, sync active-high reset, clock enable
//   sN_avalid/addr/wdata/wstrb_i, sN_ready_o : request side of port N
//   sN_rdata_o, sN_rvalid_o                 : read response to port N
//   m_avalid/addr/wdata/wstrb_o, m_ready_i  : request to memory
//   m_rdata_i, m_rvalid_i                   : read response from memory
//   cnt0_o, cnt1_o                          : accepted requests per port
module iob_bus_arbiter_2to1
    import iob_bus_arbiter_2to1_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = FIXED_PRIO_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,

    input  logic                s0_avalid_i,
    input  logic [ADDR_W-1:0]   s0_addr_i,
    input  logic [DATA_W-1:0]   s0_wdata_i,
    input  logic [DATA_W/8-1:0] s0_wstrb_i,
    output logic                s0_ready_o,
    output logic [DATA_W-1:0]   s0_rdata_o,
    output logic                s0_rvalid_o,

    input  logic                s1_avalid_i,
    input  logic [ADDR_W-1:0]   s1_addr_i,
    input  logic [DATA_W-1:0]   s1_wdata_i,
    input  logic [DATA_W/8-1:0] s1_wstrb_i,
    output logic                s1_ready_o,
    output logic [DATA_W-1:0]   s1_rdata_o,
    output logic                s1_rvalid_o,

    output logic                m_avalid_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic                m_ready_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_rvalid_i,

    output logic [CNT_W-1:0]    cnt0_o,
    output logic [CNT_W-1:0]    cnt1_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic idle, rd_wait, gnt_vld, gnt, accept, gnt_is_rd, rsp_vld;

    // Outputs are held quiet while reset is asserted, so masking with
    // rst_i gives the all-zero reset picture without waiting an edge.
    assign idle    = (state_q == ST_IDLE)    & ~rst_i;
    assign rd_wait = (state_q == ST_RD_WAIT) & ~rst_i;

    iob_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cke_i     (cke_i),
        .req_i     ({s1_avalid_i, s0_avalid_i} & {2{idle}}),
        .upd_i     (accept),
        .gnt_vld_o (gnt_vld),
        .gnt_o     (gnt)
    );

    // Request mux: zero-latency pass-through of the granted port.
    always_comb begin
        m_avalid_o = 1'b0;
        m_addr_o   = '0;
        m_wdata_o  = '0;
        m_wstrb_o  = '0;
        s0_ready_o = 1'b0;
        s1_ready_o = 1'b0;
        if (gnt_vld) begin
            m_avalid_o = 1'b1;
            if (gnt) begin
                m_addr_o   = s1_addr_i;
                m_wdata_o  = s1_wdata_i;
                m_wstrb_o  = s1_wstrb_i;
                s1_ready_o = m_ready_i;
            end else begin
                m_addr_o   = s0_addr_i;
                m_wdata_o  = s0_wdata_i;
                m_wstrb_o  = s0_wstrb_i;
                s0_ready_o = m_ready_i;
            end
        end
    end

    assign accept    = m_avalid_o & m_ready_i;
    assign gnt_is_rd = gnt ? (s1_wstrb_i == '0) : (s0_wstrb_i == '0);

    // Response steering: only the owner of the outstanding read sees it.
    // A response arriving in IDLE has no owner and is dropped.
    assign rsp_vld     = rd_wait & m_rvalid_i;
    assign s0_rvalid_o = rsp_vld & ~owner_q;
    assign s1_rvalid_o = rsp_vld &  owner_q;
    assign s0_rdata_o  = {DATA_W{s0_rvalid_o}} & m_rdata_i;
    assign s1_rdata_o  = {DATA_W{s1_rvalid_o}} & m_rdata_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                if (gnt) cnt1_d = cnt1_q + CNT_ONE;
                else     cnt0_d = cnt0_q + CNT_ONE;
                // Writes complete on accept; only reads need a response.
                if (gnt_is_rd) begin
                    owner_d = gnt;
                    state_d = ST_RD_WAIT;
                end
            end
        end else if (m_rvalid_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;

endmodule

// File: tb/tb_iob_bus_arbiter_2to1.sv
// Bench for the 2:1 IOb arbiter. Two instances run side by side:
// d=0 round-robin, d=1 fixed priority, both with 4-bit counters.
module tb_iob_bus_arbiter_2to1;

    logic clk = 1'b0;
    logic rst, cke;

    logic        av  [2][2];
    logic [31:0] ad  [2][2];
    logic [31:0] wd  [2][2];
    logic [3:0]  ws  [2][2];
    logic        rdy [2][2];
    logic        rv  [2][2];
    logic [31:0] rd  [2][2];

    logic        mav [2];
    logic [31:0] mad [2];
    logic [31:0] mwd [2];
    logic [3:0]  mws [2];
    logic        mrdy[2];
    logic        mrv [2];
    logic [31:0] mrd [2];
    logic [3:0]  c0  [2];
    logic [3:0]  c1  [2];

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        iob_bus_arbiter_2to1 #(
            .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(g), .CNT_W(4)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .cke_i       (cke),
            .s0_avalid_i (av[g][0]),
            .s0_addr_i   (ad[g][0]),
            .s0_wdata_i  (wd[g][0]),
            .s0_wstrb_i  (ws[g][0]),
            .s0_ready_o  (rdy[g][0]),
            .s0_rdata_o  (rd[g][0]),
            .s0_rvalid_o (rv[g][0]),
            .s1_avalid_i (av[g][1]),
            .s1_addr_i   (ad[g][1]),
            .s1_wdata_i  (wd[g][1]),
            .s1_wstrb_i  (ws[g][1]),
            .s1_ready_o  (rdy[g][1]),
            .s1_rdata_o  (rd[g][1]),
            .s1_rvalid_o (rv[g][1]),
            .m_avalid_o  (mav[g]),
            .m_addr_o    (mad[g]),
            .m_wdata_o   (mwd[g]),
            .m_wstrb_o   (mws[g]),
            .m_ready_i   (mrdy[g]),
            .m_rdata_i   (mrd[g]),
            .m_rvalid_i  (mrv[g]),
            .cnt0_o      (c0[g]),
            .cnt1_o      (c1[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_in();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                av[d][p] = 1'b0; ad[d][p] = '0; wd[d][p] = '0; ws[d][p] = '0;
            end
            mrdy[d] = 1'b0; mrv[d] = 1'b0; mrd[d] = '0;
        end
    endtask

    task automatic rst_cycle();
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state: which port owns the outstanding read (-1 none),
    // who won last, accept counts. Requesters hold a request until accepted;
    // memory answers each read after a random delay.
    int          own  [2];
    int          last [2];
    int          cnt  [2][2];
    bit          has  [2][2];
    logic [31:0] ra   [2][2];
    logic [31:0] rw   [2][2];
    logic [3:0]  rs   [2][2];
    int          mcnt [2];
    logic [31:0] mdat [2];

    task automatic rnd_cycle(input bit do_rst);
        int   g;
        bit   acc;
        logic e_rdy [2];
        logic e_rv  [2];
        logic [31:0] e_rd [2];
        logic [31:0] e_ad, e_wd;
        logic [3:0]  e_ws;
        string t;

        rst = do_rst;
        cke = ($urandom_range(0, 7) != 0);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (!has[d][p]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        has[d][p] = 1'b1;
                        ra[d][p]  = $urandom;
                        rw[d][p]  = $urandom;
                        rs[d][p]  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    has[d][p] = 1'b0;   // requester withdraws before accept
                end
                av[d][p] = has[d][p];
                ad[d][p] = has[d][p] ? ra[d][p] : $urandom;
                wd[d][p] = has[d][p] ? rw[d][p] : $urandom;
                ws[d][p] = has[d][p] ? rs[d][p] : 4'($urandom);
            end
            mrdy[d] = ($urandom_range(0, 1) == 1);
            if (mcnt[d] == 0) begin
                mrv[d] = 1'b1; mrd[d] = mdat[d];
            end else if (mcnt[d] < 0 && $urandom_range(0, 31) == 0) begin
                mrv[d] = 1'b1; mrd[d] = $urandom;      // stray response
            end else begin
                mrv[d] = 1'b0; mrd[d] = $urandom;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            g = -1;
            e_ad = '0; e_wd = '0; e_ws = '0;
            for (int p = 0; p < 2; p++) begin
                e_rdy[p] = 1'b0; e_rv[p] = 1'b0; e_rd[p] = '0;
            end
            if (!rst) begin
                if (own[d] < 0) begin
                    if (has[d][0] && has[d][1]) g = (d == 1) ? 1 : 1 - last[d];
                    else if (has[d][0])        g = 0;
                    else if (has[d][1])        g = 1;
                    if (g >= 0) begin
                        e_ad = ra[d][g]; e_wd = rw[d][g]; e_ws = rs[d][g];
                        e_rdy[g] = mrdy[d];
                    end
                end else if (mrv[d]) begin
                    e_rv[own[d]] = 1'b1;
                    e_rd[own[d]] = mrd[d];
                end
            end
            t = $sformatf("d%0d ", d);
            chk({t, "m_avalid"}, 32'(mav[d]), 32'(g >= 0));
            chk({t, "m_addr"},   mad[d], e_ad);
            chk({t, "m_wdata"},  mwd[d], e_wd);
            chk({t, "m_wstrb"},  32'(mws[d]), 32'(e_ws));
            for (int p = 0; p < 2; p++) begin
                chk({t, $sformatf("s%0d_ready", p)},  32'(rdy[d][p]), 32'(e_rdy[p]));
                chk({t, $sformatf("s%0d_rvalid", p)}, 32'(rv[d][p]),  32'(e_rv[p]));
                chk({t, $sformatf("s%0d_rdata", p)},  rd[d][p],       e_rd[p]);
                chk({t, $sformatf("cnt%0d", p)},
                    32'(p == 0 ? c0[d] : c1[d]), 32'(cnt[d][p]));
            end
            // advance model to what the next edge should produce
            acc = !rst && cke && g >= 0 && mrdy[d];
            if (mrv[d] && cke && mcnt[d] == 0) mcnt[d] = -1;
            else if (mcnt[d] > 0)             mcnt[d]--;
            if (rst) begin
                own[d] = -1; last[d] = 1; cnt[d][0] = 0; cnt[d][1] = 0;
            end else if (cke) begin
                if (own[d] >= 0) begin
                    if (mrv[d]) own[d] = -1;
                end else if (acc) begin
                    last[d] = g;
                    cnt[d][g] = (cnt[d][g] + 1) % 16;
                    if (rs[d][g] == 4'h0) begin
                        own[d]  = g;
                        mcnt[d] = $urandom_range(0, 3);
                        mdat[d] = $urandom;
                    end
                end
            end
            if (acc) has[d][g] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        cke = 1'b1;
        rst = 1'b1;
        idle_in();
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst m_avalid", 32'(mav[d]), 0);
            chk("rst m_addr",   mad[d], 0);
            chk("rst s0_ready", 32'(rdy[d][0]), 0);
            chk("rst s1_rvalid", 32'(rv[d][1]), 0);
            chk("rst cnt0", 32'(c0[d]), 0);
            chk("rst cnt1", 32'(c1[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Port 0 read 0x100, response 0xDEADBEEF two cycles later; port 1
        // write queued behind it, then port 0 again right after the write.
        for (int d = 0; d < 2; d++) begin
            av[d][0] = 1'b1; ad[d][0] = 32'h100; mrdy[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rd m_avalid", 32'(mav[d]), 1);
            chk("rd m_addr",   mad[d], 32'h100);
            chk("rd s0_ready", 32'(rdy[d][0]), 1);
            chk("rd s1_ready", 32'(rdy[d][1]), 0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            av[d][0] = 1'b0; mrdy[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("wait m_avalid", 32'(mav[d]), 0);
            chk("wait s0_rvalid", 32'(rv[d][0]), 0);
            chk("wait cnt0", 32'(c0[d]), 1);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            mrv[d] = 1'b1; mrd[d] = 32'hDEADBEEF;
            av[d][1] = 1'b1; ad[d][1] = 32'h200; wd[d][1] = 32'hCAFE0000; ws[d][1] = 4'hF;
            mrdy[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rsp s0_rvalid", 32'(rv[d][0]), 1);
            chk("rsp s0_rdata",  rd[d][0], 32'hDEADBEEF);
            chk("rsp s1_rvalid", 32'(rv[d][1]), 0);
            chk("rsp s1_rdata",  rd[d][1], 0);
            chk("rsp s1_ready",  32'(rdy[d][1]), 0);
            chk("rsp m_avalid",  32'(mav[d]), 0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            mrv[d] = 1'b0; mrd[d] = '0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("wr m_avalid", 32'(mav[d]), 1);
            chk("wr m_addr",   mad[d], 32'h200);
            chk("wr m_wdata",  mwd[d], 32'hCAFE0000);
            chk("wr m_wstrb",  32'(mws[d]), 32'hF);
            chk("wr s1_ready", 32'(rdy[d][1]), 1);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            av[d][1] = 1'b0; av[d][0] = 1'b1; ad[d][0] = 32'h104;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("post-wr m_addr", mad[d], 32'h104);
            chk("post-wr s1_rvalid", 32'(rv[d][1]), 0);
            chk("post-wr cnt1", 32'(c1[d]), 1);
        end
        @(negedge clk);

        // Tie with writes for 5 cycles: d0 alternates 0,1,0,1,0, d1 always 1.
        rst_cycle();
        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    av[d][p] = 1'b1; ad[d][p] = 32'(16 * p + i); ws[d][p] = 4'hF;
                end
                mrdy[d] = 1'b1;
            end
            #1;
            chk("tie d0 s0_ready", 32'(rdy[0][0]), 32'(i % 2 == 0));
            chk("tie d0 s1_ready", 32'(rdy[0][1]), 32'(i % 2 == 1));
            chk("tie d1 s1_ready", 32'(rdy[1][1]), 1);
            chk("tie d1 s0_ready", 32'(rdy[1][0]), 0);
            chk("tie d1 m_addr",   mad[1], 32'(16 + i));
            @(negedge clk);
        end
        idle_in();
        #1;
        chk("tie d0 cnt0", 32'(c0[0]), 3);
        chk("tie d0 cnt1", 32'(c1[0]), 2);
        chk("tie d1 cnt0", 32'(c0[1]), 0);
        chk("tie d1 cnt1", 32'(c1[1]), 5);
        @(negedge clk);

        // Read accepted, reset next cycle, late response must be dropped.
        rst_cycle();
        for (int d = 0; d < 2; d++) begin
            av[d][0] = 1'b1; ad[d][0] = 32'h300; mrdy[d] = 1'b1;
        end
        @(negedge clk);
        idle_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mrv[d] = 1'b1; mrd[d] = 32'h12345678;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("late s0_rvalid", 32'(rv[d][0]), 0);
            chk("late s1_rvalid", 32'(rv[d][1]), 0);
            chk("late s0_rdata",  rd[d][0], 0);
            chk("late cnt0", 32'(c0[d]), 0);
        end
        @(negedge clk);

        // 16 port-0 writes with one cke-low cycle in the middle: wraps to 0.
        rst_cycle();
        for (int i = 0; i < 17; i++) begin
            cke = (i != 5);
            for (int d = 0; d < 2; d++) begin
                av[d][0] = 1'b1; ad[d][0] = 32'(i); ws[d][0] = 4'h1; mrdy[d] = 1'b1;
            end
            #1;
            if (i == 6) begin
                chk("cke d0 cnt0", 32'(c0[0]), 5);
                chk("cke d1 cnt0", 32'(c0[1]), 5);
            end
            @(negedge clk);
        end
        cke = 1'b1;
        idle_in();
        #1;
        chk("wrap d0 cnt0", 32'(c0[0]), 0);
        chk("wrap d1 cnt0", 32'(c0[1]), 0);
        @(negedge clk);

        // Randomized traffic against the model, with occasional resets.
        for (int d = 0; d < 2; d++) begin
            own[d] = -1; last[d] = 1; mcnt[d] = -1; mdat[d] = '0;
            for (int p = 0; p < 2; p++) begin
                cnt[d][p] = 0; has[d][p] = 1'b0;
            end
        end
        rnd_cycle(1'b1);
        for (int i = 0; i < 3000; i++) begin
            rnd_cycle($urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
